// File: rtl/core_pkg.sv
// Shared encodings for the exec_ctrl sequencer: FSM states, opcodes,
// write-back selects, error codes and the instruction classifier.
package core_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [2:0] F3_ZERO    = 3'b000;

  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_PC4 = 2'b01;
  localparam logic [1:0] WB_SEL_IMM = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4,
    ERR    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ADDI  = 3'd0,
    OP_LUI   = 3'd1,
    OP_AUIPC = 3'd2,
    OP_JAL   = 3'd3,
    OP_JALR  = 3'd4
  } op_t;

  typedef struct packed {
    logic legal;
    op_t  op;
  } dec_t;

  // Maps decoder fields onto the five supported instruction classes.
  function automatic dec_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
    dec_t d;
    d.legal = 1'b1;
    d.op    = OP_ADDI;
    case (opcode)
      OPC_OP_IMM: begin
        d.op    = OP_ADDI;
        d.legal = (funct3 == F3_ZERO);
      end
      OPC_LUI:   d.op = OP_LUI;
      OPC_AUIPC: d.op = OP_AUIPC;
      OPC_JAL:   d.op = OP_JAL;
      OPC_JALR: begin
        d.op    = OP_JALR;
        d.legal = (funct3 == F3_ZERO);
      end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Instruction-fetch bus between exec_ctrl (master) and instruction memory (slave).
interface exec_ctrl_if;
  // Handshake: the master holds imem_req high with a stable imem_addr for as
  // long as it waits; the slave answers with imem_ack for exactly the cycle in
  // which imem_rdata is valid. An ack while imem_req is low is ignored.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/exec_ctrl_fetch_timer.sv
// Counts ack-less fetch cycles; expire_o flags the last allowed wait cycle.
module fetch_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle that would make the wait count reach TIMEOUT is the expiring one.
  assign expire_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle control sequencer: fetch, decode, execute, write-back for a
// small RV32I subset, with halt on ebreak and error on illegal/timeout.
module exec_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  exec_ctrl_if.master        imem,
  output logic [31:0]        ir,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [4:0]         rd,
  input  logic [31:0]        alu_s,
  output logic               alu_a_sel,
  output logic [1:0]         wb_sel,
  output logic               rf_wen,
  output logic [31:0]        pc,
  output logic [31:0]        instret,
  output logic               halted,
  output logic               error,
  output logic [1:0]         err_code,
  output state_t             dbg_state_o
);

  state_t      state_q;
  op_t         op_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] instret_q;
  logic [31:0] result_q;
  logic [1:0]  err_q;

  logic        in_fetch;
  logic        fetch_ack;
  logic        timer_expire;
  logic [31:0] pc_d;
  dec_t        dec;

  assign in_fetch  = (state_q == FETCH);
  assign fetch_ack = in_fetch && imem.imem_ack;
  assign dec       = classify(opcode, funct3);

  fetch_timer #(
    .TIMEOUT (FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!in_fetch),
    .inc_i    (in_fetch && !imem.imem_ack),
    .expire_o (timer_expire)
  );

  always_comb begin
    pc_d = pc_q + 32'd4;
    case (op_q)
      OP_JAL:  pc_d = result_q;
      OP_JALR: pc_d = result_q & ~32'h1;
      default: pc_d = pc_q + 32'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      op_q      <= OP_ADDI;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
      result_q  <= '0;
      err_q     <= ERR_NONE;
    end else begin
      case (state_q)
        FETCH: begin
          if (fetch_ack) begin
            ir_q    <= imem.imem_rdata;
            state_q <= DECODE;
          end else if (timer_expire) begin
            err_q   <= ERR_TIMEOUT;
            state_q <= ERR;
          end
        end
        DECODE: begin
          // ebreak is matched on the whole word before the opcode classifier.
          if (ir_q == INSN_EBREAK) begin
            state_q <= HALT;
          end else if (dec.legal) begin
            op_q    <= dec.op;
            state_q <= EXEC;
          end else begin
            err_q   <= ERR_ILLEGAL;
            state_q <= ERR;
          end
        end
        EXEC: begin
          result_q <= alu_s;
          state_q  <= WB;
        end
        WB: begin
          pc_q      <= pc_d;
          instret_q <= instret_q + 32'd1;
          state_q   <= FETCH;
        end
        HALT:    state_q <= HALT;
        ERR:     state_q <= ERR;
        default: state_q <= ERR;
      endcase
    end
  end

  always_comb begin
    wb_sel = WB_SEL_ALU;
    if (state_q == WB) begin
      case (op_q)
        OP_LUI:          wb_sel = WB_SEL_IMM;
        OP_JAL, OP_JALR: wb_sel = WB_SEL_PC4;
        default:         wb_sel = WB_SEL_ALU;
      endcase
    end
  end

  // Strobes are held low while rst is high, whatever state is still registered.
  assign imem.imem_req  = !rst && in_fetch;
  assign imem.imem_addr = pc_q;
  assign rf_wen         = !rst && (state_q == WB) && (rd != 5'd0);
  assign alu_a_sel      = (state_q == EXEC) && ((op_q == OP_AUIPC) || (op_q == OP_JAL));
  assign halted         = !rst && (state_q == HALT);
  assign error          = !rst && (state_q == ERR);
  assign err_code       = err_q;
  assign ir             = ir_q;
  assign pc             = pc_q;
  assign instret        = instret_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: a vector table of instructions run back to
// back, plus hand-written reset, terminal-state and fetch-timeout sequences.
module tb_exec_ctrl;
  import core_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_s;
  logic        alu_a_sel;
  logic [1:0]  wb_sel;
  logic        rf_wen;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        halted;
  logic        error;
  logic [1:0]  err_code;
  state_t      dbg_state;

  int checks   = 0;
  int failures = 0;

  exec_ctrl_if bus ();

  exec_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .ir          (ir),
    .opcode      (opcode),
    .funct3      (funct3),
    .rd          (rd),
    .alu_s       (alu_s),
    .alu_a_sel   (alu_a_sel),
    .wb_sel      (wb_sel),
    .rf_wen      (rf_wen),
    .pc          (pc),
    .instret     (instret),
    .halted      (halted),
    .error       (error),
    .err_code    (err_code),
    .dbg_state_o (dbg_state)
  );

  // External decoder stand-in.
  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign rd     = ir[11:7];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu;
    int          delay;
    logic        exp_a_sel;
    logic [1:0]  exp_wb;
    logic        exp_wen;
    logic [31:0] exp_pc;
    logic [31:0] exp_instret;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] prev_pc;
  logic [31:0] prev_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_quiet();
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs one instruction starting at posedge+1 of its first FETCH cycle and
  // returns at posedge+1 of the following FETCH cycle.
  task automatic run_vec(input int k);
    vec_t        v;
    logic [31:0] req_pat;
    logic [31:0] wen_pat;
    logic [31:0] addr0;
    logic [31:0] ir_wait;
    logic [31:0] ir_dec;
    logic        a_sel;
    logic [1:0]  wb;
    v = vecs[k];
    req_pat = '0;
    wen_pat = '0;
    addr0   = '0;
    ir_wait = '0;
    ir_dec  = '0;
    a_sel   = 1'b0;
    wb      = 2'b00;
    bus.imem_rdata = v.instr;
    alu_s          = v.alu;
    for (int i = 0; i <= v.delay + 3; i++) begin
      bus.imem_ack = (i == v.delay);
      @(negedge clk);
      req_pat[i] = bus.imem_req;
      wen_pat[i] = rf_wen;
      if (i == 0)           addr0   = bus.imem_addr;
      if (i == v.delay)     ir_wait = ir;
      if (i == v.delay + 1) ir_dec  = ir;
      if (i == v.delay + 2) a_sel   = alu_a_sel;
      if (i == v.delay + 3) wb      = wb_sel;
      @(posedge clk);
      #1;
    end
    bus.imem_ack = 1'b0;
    check($sformatf("v%0d_addr", k), addr0, prev_pc);
    check($sformatf("v%0d_ir_wait", k), ir_wait, prev_ir);
    check($sformatf("v%0d_ir", k), ir_dec, v.instr);
    check($sformatf("v%0d_req_pattern", k), req_pat, (32'd1 << (v.delay + 1)) - 32'd1);
    check($sformatf("v%0d_wen_pattern", k), wen_pat, 32'(v.exp_wen) << (v.delay + 3));
    check($sformatf("v%0d_alu_a_sel", k), 32'(a_sel), 32'(v.exp_a_sel));
    check($sformatf("v%0d_wb_sel", k), 32'(wb), 32'(v.exp_wb));
    check($sformatf("v%0d_pc", k), pc, v.exp_pc);
    check($sformatf("v%0d_instret", k), instret, v.exp_instret);
    check($sformatf("v%0d_req_next", k), 32'(bus.imem_req), 32'd1);
    prev_pc = v.exp_pc;
    prev_ir = v.instr;
  endtask

  // Reset, retire one addi, then fetch an instruction that must end in HALT or ERR.
  task automatic run_term(input string tag, input logic [31:0] instr,
                          input logic exp_halt, input logic exp_err, input logic [1:0] exp_code);
    logic any_wen;
    logic any_req;
    reset_quiet();
    bus.imem_rdata = 32'h0050_0093;
    alu_s          = 32'h5;
    bus.imem_ack   = 1'b1;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    any_wen = 1'b0;
    any_req = 1'b0;
    bus.imem_rdata = instr;
    bus.imem_ack   = 1'b1;
    @(negedge clk);
    any_wen |= rf_wen;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    any_wen |= rf_wen;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.imem_ack = 1'b1;
      @(negedge clk);
      any_wen |= rf_wen;
      any_req |= bus.imem_req;
      @(posedge clk); #1;
    end
    bus.imem_ack = 1'b0;
    @(negedge clk);
    check({tag, "_halted"}, 32'(halted), 32'(exp_halt));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
    check({tag, "_no_wen"}, 32'(any_wen), 32'd0);
    check({tag, "_no_req"}, 32'(any_req), 32'd0);
    check({tag, "_pc"}, pc, 32'h8000_0004);
    check({tag, "_instret"}, instret, 32'd1);
    check({tag, "_ir"}, ir, instr);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs[0] = '{32'h0050_0093, 32'h0000_0005, 0, 1'b0, 2'b00, 1'b1, 32'h8000_0004, 32'd1};
    vecs[1] = '{32'h0080_00EF, 32'h8000_0008, 0, 1'b1, 2'b01, 1'b1, 32'h8000_0008, 32'd2};
    vecs[2] = '{32'h0001_00E7, 32'h8000_0011, 0, 1'b0, 2'b01, 1'b1, 32'h8000_0010, 32'd3};
    vecs[3] = '{32'h1234_52B7, 32'hDEAD_BEEF, 3, 1'b0, 2'b10, 1'b1, 32'h8000_0014, 32'd4};
    vecs[4] = '{32'h0000_1197, 32'h8000_1014, 1, 1'b1, 2'b00, 1'b1, 32'h8000_0018, 32'd5};
    vecs[5] = '{32'h0000_0013, 32'h0000_0000, 0, 1'b0, 2'b00, 1'b0, 32'h8000_001C, 32'd6};
    vecs[6] = '{32'h0000_006F, 32'hFFFF_FFFC, 2, 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'd7};
    vecs[7] = '{32'h0010_0113, 32'h0000_0001, 0, 1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'd8};

    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    alu_s          = '0;
    prev_pc        = 32'h8000_0000;
    prev_ir        = '0;

    // Reset state, observed while rst is still high.
    @(posedge clk); #1;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_wen", 32'(rf_wen), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_instret", instret, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run_vec(k);
    end

    // Reset asserted while an instruction is in EXEC.
    bus.imem_rdata = 32'h0050_0093;
    alu_s          = 32'h5;
    bus.imem_ack   = 1'b1;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rexec_req", 32'(bus.imem_req), 32'd0);
    check("rexec_wen", 32'(rf_wen), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rexec_pc", pc, 32'h8000_0000);
    check("rexec_instret", instret, 32'd0);
    check("rexec_ir", ir, 32'd0);
    check("rexec_req_hold", 32'(bus.imem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rexec_req_after", 32'(bus.imem_req), 32'd1);
    check("rexec_addr_after", bus.imem_addr, 32'h8000_0000);
    @(posedge clk); #1;

    run_term("illegal", 32'hFFFF_FFFF, 1'b0, 1'b1, ERR_ILLEGAL);
    run_term("jalr_f3", 32'h0001_10E7, 1'b0, 1'b1, ERR_ILLEGAL);
    run_term("ebreak", INSN_EBREAK, 1'b1, 1'b0, ERR_NONE);

    // Fetch timeout: 255 ack-less cycles in FETCH end in ERR.
    reset_quiet();
    bus.imem_rdata = 32'h0050_0093;
    for (int i = 0; i < 255; i++) begin
      if (i == 254) begin
        @(negedge clk);
        check("tmo_last_req", 32'(bus.imem_req), 32'd1);
        check("tmo_last_error", 32'(error), 32'd0);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_err_code", 32'(err_code), 32'(ERR_TIMEOUT));
    check("tmo_state", 32'(dbg_state), 32'(ERR));
    check("tmo_req", 32'(bus.imem_req), 32'd0);
    check("tmo_ir", ir, 32'd0);
    check("tmo_pc", pc, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
